// File: rtl/lock_arbiter_if.sv
// Command/ack stream bundle for the hardware lock service.
// Commands flow master -> slave on in_*; acks flow slave -> master on out_*.
interface lock_arbiter_if #(
   parameter int ACC_ID_BITS = 4
) ();
   logic [63:0]            in_tdata;
   logic                   in_tvalid;
   logic                   in_tready;
   logic [ACC_ID_BITS-1:0] in_tid;
   logic [63:0]            out_tdata;
   logic                   out_tvalid;
   logic                   out_tready;
   logic [ACC_ID_BITS-1:0] out_tdest;

   modport slave (
      input  in_tdata, in_tvalid, in_tid, out_tready,
      output in_tready, out_tdata, out_tvalid, out_tdest
   );

   modport master (
      output in_tdata, in_tvalid, in_tid, out_tready,
      input  in_tready, out_tdata, out_tvalid, out_tdest
   );
endinterface

// File: rtl/lock_arbiter.sv
// Hardware lock service: per-lock busy/owner table driven by single-word lock/unlock
// commands, answering LOCK requests with an OK/REJECT ack routed back to the requester.
module lock_arbiter #(
   parameter int ACC_ID_BITS  = 4,
   parameter int LOCK_ID_BITS = 8
) (
   input  logic           clk,
   input  logic           rstn,
   lock_arbiter_if.slave  bus,
   output logic           err_unlock,
   output logic           err_cmd
);
   localparam int         NUM_LOCKS  = 1 << LOCK_ID_BITS;
   localparam logic [7:0] CMD_LOCK   = 8'h04;
   localparam logic [7:0] CMD_UNLOCK = 8'h06;
   localparam logic [7:0] ACK_OK     = 8'h01;
   localparam logic [7:0] ACK_REJECT = 8'h00;

   typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;

   state_t                  state, state_nxt;
   logic                    ready_q;
   logic [7:0]              cmd_code_p0;
   logic [7:0]              cmd_lock_p0;
   logic [ACC_ID_BITS-1:0]  cmd_tid_p0;
   logic [7:0]              ack_code_p1;
   logic [7:0]              ack_lock_p1;
   logic [ACC_ID_BITS-1:0]  ack_dest_p1;
   logic                    vld_p1;
   logic [NUM_LOCKS-1:0]    busy;
   logic [ACC_ID_BITS-1:0]  owner [NUM_LOCKS];
   logic [LOCK_ID_BITS-1:0] lock_idx;
   logic                    accept, ack_load, lock_grant, unlock_ok, unlock_bad, bad_cmd;
   logic                    unused_tdata;

   // Only [15:0] of a command carries meaning; the upper lock-id bits beyond LOCK_ID_BITS alias.
   assign unused_tdata = ^bus.in_tdata[63:16];
   assign lock_idx     = cmd_lock_p0[LOCK_ID_BITS-1:0];

   assign bus.in_tready  = ready_q;
   assign bus.out_tvalid = vld_p1;
   assign bus.out_tdata  = {48'd0, ack_lock_p1, ack_code_p1};
   assign bus.out_tdest  = ack_dest_p1;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      ack_load   = 1'b0;
      lock_grant = 1'b0;
      unlock_ok  = 1'b0;
      unlock_bad = 1'b0;
      bad_cmd    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.in_tvalid && ready_q) begin
               accept    = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            state_nxt = IDLE;
            if (cmd_code_p0 == CMD_LOCK) begin
               // Locks are non-reentrant: a busy lock is rejected even for its owner.
               ack_load   = 1'b1;
               lock_grant = !busy[lock_idx];
               state_nxt  = ACK;
            end else if (cmd_code_p0 == CMD_UNLOCK) begin
               if (busy[lock_idx] && owner[lock_idx] == cmd_tid_p0) unlock_ok  = 1'b1;
               else                                                 unlock_bad = 1'b1;
            end else begin
               bad_cmd = 1'b1;
            end
         end
         ACK: begin
            if (bus.out_tready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // p0: accepted command; p1: ack held until the return interconnect takes it
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ready_q     <= 1'b0;
         vld_p1      <= 1'b0;
         err_unlock  <= 1'b0;
         err_cmd     <= 1'b0;
         cmd_code_p0 <= '0;
         cmd_lock_p0 <= '0;
         cmd_tid_p0  <= '0;
         ack_code_p1 <= '0;
         ack_lock_p1 <= '0;
         ack_dest_p1 <= '0;
         busy        <= '0;
         for (int i = 0; i < NUM_LOCKS; i++) owner[i] <= '0;
      end else begin
         ready_q    <= (state_nxt == IDLE);
         vld_p1     <= (state_nxt == ACK);
         err_unlock <= unlock_bad;
         err_cmd    <= bad_cmd;
         if (accept) begin
            cmd_code_p0 <= bus.in_tdata[7:0];
            cmd_lock_p0 <= bus.in_tdata[15:8];
            cmd_tid_p0  <= bus.in_tid;
         end
         if (ack_load) begin
            ack_code_p1 <= lock_grant ? ACK_OK : ACK_REJECT;
            ack_lock_p1 <= cmd_lock_p0;
            ack_dest_p1 <= cmd_tid_p0;
         end
         if (lock_grant) begin
            busy[lock_idx]  <= 1'b1;
            owner[lock_idx] <= cmd_tid_p0;
         end
         if (unlock_ok) busy[lock_idx] <= 1'b0;
      end
   end
endmodule
